// File: rtl/interrupt_ack_control_pkg.sv
// interrupt_ack_control_pkg: shared types and constants for the INTA sequencer.
package interrupt_ack_control_pkg;
  typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} ack_state_t;
  localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIORITY = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;
  localparam logic [7:0] CALL_OPCODE        = 8'hCD;
  localparam logic [2:0] PRIORITY_NO_ROTATE = 3'b111;
  function automatic logic [7:0] level_mask(input logic [2:0] l);
    return 8'b1 << l;
  endfunction
endpackage

// File: rtl/interrupt_ack_control_if.sv
// interrupt_ack_control_if: request, command and CPU bus signals of the INTA sequencer.
interface interrupt_ack_control_if;
  logic       inta_n;
  logic [7:0] highest_request;
  logic [7:0] highest_level_in_service;
  logic       mode_8086;
  logic       auto_eoi;
  logic [4:0] vector_base;
  logic [10:0] call_addr;
  logic       ocw2_write;
  logic [7:0] ocw2;
  logic [7:0] interrupt;
  logic [7:0] end_interrupt;
  logic [2:0] priority_rotate;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_out_en;
  modport master (
    output inta_n, highest_request, highest_level_in_service, mode_8086, auto_eoi,
           vector_base, call_addr, ocw2_write, ocw2,
    input  interrupt, end_interrupt, priority_rotate, int_out, data_out, data_out_en
  );
  modport slave (
    input  inta_n, highest_request, highest_level_in_service, mode_8086, auto_eoi,
           vector_base, call_addr, ocw2_write, ocw2,
    output interrupt, end_interrupt, priority_rotate, int_out, data_out, data_out_en
  );
endinterface

// File: rtl/pic_level_encoder.sv
// pic_level_encoder: one-hot to 3-bit level encode, 0 for an all-zero input.
module pic_level_encoder (
  input  logic [7:0] onehot,
  output logic [2:0] level
);
  always_comb begin
    level = '0;
    for (int i = 0; i < 8; i++) level = onehot[i] ? (level | 3'(i)) : level;
  end
endmodule

// File: rtl/interrupt_ack_control.sv
// interrupt_ack_control: 8259-style INTA sequencer with vector/CALL output and EOI/rotation control.
module interrupt_ack_control
  import interrupt_ack_control_pkg::*;
(
  input logic clk,
  input logic reset,
  interrupt_ack_control_if.slave bus
);
  ack_state_t state, state_n;
  logic       inta_q, mode_q, spurious, rotate_aeoi;
  logic [2:0] level, level_n, req_level, isr_level, cmd, ocw_l;
  logic       fall, rise, last_end, mode_n, drive, aeoi, ns_eoi, sp_eoi, ocw_rot;
  logic [7:0] byte_n, ocw_mask;
  logic       unused_ocw2;
  pic_level_encoder req_enc (.onehot(bus.highest_request), .level(req_level));
  pic_level_encoder isr_enc (.onehot(bus.highest_level_in_service), .level(isr_level));
  assign fall = inta_q & ~bus.inta_n;
  assign rise = ~inta_q & bus.inta_n;
  assign last_end = rise & ((state == ACK2 & mode_q) | state == ACK3);
  assign mode_n = (state == IDLE) ? bus.mode_8086 : mode_q;
  assign level_n = (state == IDLE) ? (|bus.highest_request ? req_level : 3'd7) : level;
  always_comb begin
    case (state)
      IDLE:    state_n = fall ? ACK1 : IDLE;
      ACK1:    state_n = fall ? ACK2 : ACK1;
      ACK2:    state_n = last_end ? IDLE : (fall & ~mode_q) ? ACK3 : ACK2;
      default: state_n = last_end ? IDLE : ACK3;
    endcase
  end
  // Bus outputs are registered from the next state, so the byte follows the INTA low edge by one clock.
  assign drive = ~bus.inta_n & ((state_n == ACK1) ? ~mode_n : state_n != IDLE);
  assign byte_n = (state_n == ACK1) ? CALL_OPCODE :
                  (state_n == ACK3) ? bus.call_addr[10:3] :
                  mode_n ? {bus.vector_base, level_n} : {bus.call_addr[2:0], level_n, 2'b00};
  assign aeoi = last_end & bus.auto_eoi & ~spurious;
  assign cmd = bus.ocw2[7:5];
  assign ocw_l = bus.ocw2[2:0];
  assign unused_ocw2 = ^bus.ocw2[4:3];
  assign ns_eoi = bus.ocw2_write & (cmd == OCW2_NS_EOI | cmd == OCW2_ROT_NS_EOI);
  assign sp_eoi = bus.ocw2_write & (cmd == OCW2_SP_EOI | cmd == OCW2_ROT_SP_EOI);
  assign ocw_mask = ns_eoi ? bus.highest_level_in_service : sp_eoi ? level_mask(ocw_l) : '0;
  assign ocw_rot = bus.ocw2_write & ((cmd == OCW2_ROT_NS_EOI & |bus.highest_level_in_service) |
                                     cmd == OCW2_ROT_SP_EOI | cmd == OCW2_SET_PRIORITY);
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      inta_q              <= 1'b1;
      mode_q              <= 1'b0;
      spurious            <= 1'b0;
      level               <= '0;
      rotate_aeoi         <= 1'b0;
      bus.interrupt       <= '0;
      bus.end_interrupt   <= '0;
      bus.priority_rotate <= PRIORITY_NO_ROTATE;
      bus.int_out         <= 1'b0;
      bus.data_out        <= '0;
      bus.data_out_en     <= 1'b0;
    end else begin
      state  <= state_n;
      inta_q <= bus.inta_n;
      if (state == IDLE && fall) begin
        mode_q   <= bus.mode_8086;
        level    <= level_n;
        spurious <= ~|bus.highest_request;
      end
      bus.interrupt       <= (state == IDLE && fall) ? bus.highest_request : '0;
      bus.int_out         <= state_n == IDLE && |bus.highest_request;
      bus.end_interrupt   <= ocw_mask | (aeoi ? level_mask(level) : '0);
      bus.priority_rotate <= ocw_rot ? (cmd == OCW2_ROT_NS_EOI ? isr_level : ocw_l) :
                             (aeoi & rotate_aeoi) ? level : bus.priority_rotate;
      rotate_aeoi         <= (bus.ocw2_write & cmd == OCW2_SET_ROT_AEOI) ? 1'b1 :
                             (bus.ocw2_write & cmd == OCW2_CLR_ROT_AEOI) ? 1'b0 : rotate_aeoi;
      bus.data_out        <= drive ? byte_n : '0;
      bus.data_out_en     <= drive;
    end
  end
endmodule

// File: tb/tb_interrupt_ack_control.sv
// tb_interrupt_ack_control: randomized scoreboard bench with a behavioural acknowledge/EOI model.
module tb_interrupt_ack_control;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  interrupt_ack_control_if bus();
  interrupt_ack_control dut (.clk(clk), .reset(reset), .bus(bus));
  int passed = 0;
  int total = 0;
  logic [7:0] int_q[$], eoi_q[$], byte_q[$];
  logic [2:0] rot_q[$];
  logic       rot_aeoi_m = 0;
  logic [2:0] prio_m = 3'b111;
  logic       en_prev = 0;
  logic [2:0] rot_prev = 3'b111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Monitor: every output event must match the oldest expectation of its kind.
  always @(negedge clk) begin
    if (bus.interrupt != 0) begin
      if (int_q.size() == 0) check("interrupt_unexpected", bus.interrupt, 0);
      else check("interrupt", bus.interrupt, int_q.pop_front());
    end
    if (bus.end_interrupt != 0) begin
      if (eoi_q.size() == 0) check("end_interrupt_unexpected", bus.end_interrupt, 0);
      else check("end_interrupt", bus.end_interrupt, eoi_q.pop_front());
    end
    if (bus.data_out_en === 1'b1 && !en_prev) begin
      if (byte_q.size() == 0) check("data_out_unexpected", {1'b1, bus.data_out}, 0);
      else check("data_out", bus.data_out, byte_q.pop_front());
    end
    if (bus.priority_rotate !== rot_prev) begin
      if (rot_q.size() == 0) check("priority_rotate_unexpected", {1'b1, bus.priority_rotate}, 0);
      else check("priority_rotate", bus.priority_rotate, rot_q.pop_front());
    end
    en_prev = bus.data_out_en === 1'b1;
    rot_prev = bus.priority_rotate;
  end

  task automatic ocw_model(input logic [7:0] o, input logic [7:0] hlis,
                           inout logic [7:0] emask, inout logic rv, inout logic [2:0] rl);
    logic [2:0] l = o[2:0];
    case (o[7:5])
      3'b001: emask |= hlis;
      3'b011: emask |= 8'(1) << l;
      3'b101: if (hlis != 0) begin emask |= hlis; rv = 1; rl = enc(hlis); end
      3'b111: begin emask |= 8'(1) << l; rv = 1; rl = l; end
      3'b110: begin rv = 1; rl = l; end
      3'b100: rot_aeoi_m = 1;
      3'b000: rot_aeoi_m = 0;
      default: ;
    endcase
  endtask

  task automatic commit(input logic [7:0] emask, input logic rv, input logic [2:0] rl);
    if (emask != 0) eoi_q.push_back(emask);
    if (rv && rl != prio_m) rot_q.push_back(rl);
    if (rv) prio_m = rl;
  endtask

  task automatic ocw_cmd(input logic [7:0] o, input logic [7:0] hlis);
    logic [7:0] emask = 0;
    logic rv = 0;
    logic [2:0] rl = 0;
    ocw_model(o, hlis, emask, rv, rl);
    commit(emask, rv, rl);
    bus.ocw2 = o;
    bus.highest_level_in_service = hlis;
    bus.ocw2_write = 1;
    @(negedge clk);
    bus.ocw2_write = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ack(input logic m8086, input logic [7:0] req, input logic aeoi,
                     input logic [4:0] vb, input logic [10:0] ca,
                     input logic ocw_en, input logic [7:0] o, input logic [7:0] hlis);
    logic [2:0] lvl = (req == 0) ? 3'd7 : enc(req);
    logic [7:0] emask;
    logic rv;
    logic [2:0] rl;
    int np = m8086 ? 2 : 3;
    if (req != 0) int_q.push_back(req);
    if (m8086) byte_q.push_back({vb, lvl});
    else begin
      byte_q.push_back(8'hCD);
      byte_q.push_back({ca[2:0], lvl, 2'b00});
      byte_q.push_back(ca[10:3]);
    end
    bus.mode_8086 = m8086;
    bus.highest_request = req;
    bus.auto_eoi = aeoi;
    bus.vector_base = vb;
    bus.call_addr = ca;
    repeat (2) @(negedge clk);
    check("int_out_pending", bus.int_out, req != 0);
    for (int p = 0; p < np; p++) begin
      bus.inta_n = 0;
      repeat ($urandom_range(2, 4)) @(negedge clk);
      if (p == 0) check("int_out_cleared", bus.int_out, 0);
      bus.inta_n = 1;
      if (p == np - 1) begin
        emask = (aeoi && req != 0) ? 8'(1) << lvl : 8'h00;
        rv = aeoi && req != 0 && rot_aeoi_m;
        rl = lvl;
        if (ocw_en) begin
          ocw_model(o, hlis, emask, rv, rl);
          bus.ocw2 = o;
          bus.highest_level_in_service = hlis;
          bus.ocw2_write = 1;
        end
        commit(emask, rv, rl);
      end
      @(negedge clk);
      bus.ocw2_write = 0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bus.highest_request = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.inta_n = 1;
    bus.highest_request = 0;
    bus.highest_level_in_service = 0;
    bus.mode_8086 = 0;
    bus.auto_eoi = 0;
    bus.vector_base = 0;
    bus.call_addr = 0;
    bus.ocw2_write = 0;
    bus.ocw2 = 0;
    repeat (2) @(negedge clk);
    check("reset_interrupt", bus.interrupt, 0);
    check("reset_end_interrupt", bus.end_interrupt, 0);
    check("reset_data_out", bus.data_out, 0);
    check("reset_data_out_en", bus.data_out_en, 0);
    check("reset_int_out", bus.int_out, 0);
    check("reset_priority_rotate", bus.priority_rotate, 3'b111);
    reset = 0;
    @(negedge clk);
    ack(1, 8'h04, 0, 5'b01000, 11'h0, 0, 0, 0);
    ack(0, 8'h20, 0, 5'h0, 11'h3A5, 0, 0, 0);
    ocw_cmd(8'h80, 0);
    ack(1, 8'h08, 1, 5'h11, 11'h0, 0, 0, 0);
    ocw_cmd(8'h00, 0);
    ack(1, 8'h00, 1, 5'h1F, 11'h0, 0, 0, 0);
    ocw_cmd(8'hA0, 8'h10);
    ocw_cmd(8'hC1, 8'h00);
    ocw_cmd(8'h20, 8'h00);
    ocw_cmd(8'h80, 0);
    ack(0, 8'h02, 1, 5'h0, 11'h7FF, 1, 8'hE5, 8'h00);
    // Reset during the second 8086 pulse abandons the sequence.
    ocw_cmd(8'h00, 0);
    int_q.push_back(8'h04);
    byte_q.push_back({5'b01000, 3'd2});
    bus.mode_8086 = 1;
    bus.auto_eoi = 1;
    bus.vector_base = 5'b01000;
    bus.highest_request = 8'h04;
    repeat (2) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      bus.inta_n = 0;
      repeat (3) @(negedge clk);
      if (p == 0) begin
        bus.inta_n = 1;
        repeat (3) @(negedge clk);
      end
    end
    reset = 1;
    bus.inta_n = 1;
    if (prio_m != 3'b111) rot_q.push_back(3'b111);
    prio_m = 3'b111;
    rot_aeoi_m = 0;
    @(negedge clk);
    check("midreset_data_out_en", bus.data_out_en, 0);
    check("midreset_priority_rotate", bus.priority_rotate, 3'b111);
    check("midreset_end_interrupt", bus.end_interrupt, 0);
    reset = 0;
    bus.highest_request = 0;
    repeat (3) @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0)
        ack(1'($urandom_range(0, 1)), 8'(1) << $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            5'($urandom), 11'($urandom), $urandom_range(0, 3) == 0, 8'($urandom),
            $urandom_range(0, 1) ? 8'(1) << $urandom_range(0, 7) : 8'h00);
      else
        ocw_cmd(8'($urandom), $urandom_range(0, 1) ? 8'(1) << $urandom_range(0, 7) : 8'h00);
    end
    repeat (5) @(negedge clk);
    check("pending_interrupt", int_q.size(), 0);
    check("pending_end_interrupt", eoi_q.size(), 0);
    check("pending_data_out", byte_q.size(), 0);
    check("pending_priority_rotate", rot_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/interrupt_ack_control.md
INTERRUPT_ACK_CONTROL -- requirements
Module: interrupt_ack_control

Interface
REQ-001 SHALL have one clock and reset; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inta_n  input  1  CPU interrupt acknowledge, active-low, synchronous to clk.
REQ-005 highest_request  input  8  one-hot highest-priority pending unmasked request (all-zero means none).
REQ-006 highest_level_in_service  input  8  one-hot highest in-service level, driven by the in-service register.
REQ-007 mode_8086  input  1  1 selects two-pulse 8086 sequence; 0 selects three-pulse 8080 CALL sequence.
REQ-008 auto_eoi  input  1  1 enables automatic EOI at the end of the last INTA pulse.
REQ-009 vector_base  input  5  8086 vector bits T7..T3.
REQ-010 call_addr  input  11  8080 CALL address bits A15..A5.
REQ-011 ocw2_write  input  1  one-cycle strobe; ocw2 is valid.
REQ-012 ocw2  input  8  OCW2 command byte: R, SL, EOI in bits 7..5; L2..L0 in bits 2..0.
REQ-013 interrupt  output  8  one-hot pulse; sets the in-service bit.
REQ-014 end_interrupt  output  8  one-hot pulse; clears in-service bits.
REQ-015 priority_rotate  output  3  lowest-priority level; 3'b111 means IR0 is highest.
REQ-016 int_out  output  1  interrupt request to the CPU.
REQ-017 data_out  output  8  vector or opcode byte.
REQ-018 data_out_en  output  1  1 while data_out is driven onto the bus.

Function
REQ-019 SHALL detect an INTA falling edge as a registered inta_n of 1 and a current inta_n of 0; a rising edge is the reverse.
REQ-020 SHALL implement states IDLE, ACK1, ACK2 and ACK3; ACK3 is used only when mode_8086 is 0.
REQ-021 In IDLE, int_out SHALL be set one cycle after highest_request becomes nonzero.
REQ-022 IDLE + falling edge -> ACK1 SHALL: latch the level (3-bit encode of highest_request, or 7 if the request is zero); pulse interrupt for one cycle only if the request is nonzero; clear int_out.
REQ-023 In 8086 mode, ACK1 SHALL drive data_out_en 0.
REQ-024 In 8080 mode, ACK1 SHALL drive data_out 8'hCD with data_out_en 1 while inta_n is low.
REQ-025 The next falling edge SHALL move ACK1 -> ACK2.
REQ-026 ACK2 in 8086 mode SHALL drive data_out = {vector_base, level}.
REQ-027 ACK2 in 8080 mode SHALL drive data_out = {call_addr[2:0], level, 2'b00}.
REQ-028 In 8080 mode, the next falling edge SHALL move ACK2 -> ACK3, and ACK3 SHALL drive data_out = call_addr[10:3].
REQ-029 data_out_en SHALL be 1 only while inta_n is low in a driving state.
REQ-030 The rising edge ending the last pulse (ACK2 in 8086 mode, ACK3 in 8080 mode) SHALL return the FSM to IDLE.
REQ-031 If auto_eoi is 1 at the end of the last pulse, SHALL pulse end_interrupt one-hot on the latched level for one cycle.
REQ-032 If auto_eoi is 1 and rotate_aeoi is set at the end of the last pulse, SHALL also set priority_rotate to the latched level.
REQ-033 A spurious level-7 acknowledge SHALL never generate an end_interrupt pulse.
REQ-034 OCW2 decode on ocw2_write (R, SL, EOI):
- 001: non-specific EOI; end_interrupt = highest_level_in_service.
- 011: specific EOI; end_interrupt = one-hot of L.
- 101: non-specific EOI plus rotate; priority_rotate = encoded highest_level_in_service.
- 111: specific EOI plus rotate; priority_rotate = L.
- 110: set priority; priority_rotate = L, no EOI.
- 100: set rotate_aeoi.
- 000: clear rotate_aeoi.
- 010: no operation.
REQ-035 A non-specific EOI (001 or 101) with highest_level_in_service 0 SHALL produce no end_interrupt pulse and no rotation.
REQ-036 When an OCW2 EOI and an auto-EOI fall in the same cycle, end_interrupt SHALL be the OR of both masks.
REQ-037 When rotations coincide, the OCW2 rotation SHALL win.
REQ-038 The interrupt and end_interrupt outputs SHALL each be registered and SHALL last exactly one cycle.
REQ-039 Changing mode_8086 mid-sequence is undefined; the FSM SHALL use the mode latched at ACK1 entry.

Reset
REQ-040 Reset SHALL put the FSM in IDLE and force interrupt, end_interrupt, data_out, data_out_en and int_out to 0.
REQ-041 Reset SHALL set priority_rotate to 3'b111 and clear rotate_aeoi.
REQ-042 Reset mid-acknowledge SHALL abandon the sequence with no EOI pulse.

Structure
REQ-043 A shared package SHALL hold: the state enum; the OCW2 command constants; the CALL opcode 8'hCD; the constant PRIORITY_NO_ROTATE = 3'b111.
REQ-044 One sub-module, pic_level_encoder, SHALL provide the one-hot to 3-bit encode (result 0 for all-zero input).

Verification
REQ-045 8086 mode, vector_base 5'b01000, highest_request 8'h04, two INTA pulses -> interrupt 8'h04 pulse on pulse 1; data_out 8'h42 on pulse 2; FSM back to IDLE.
REQ-046 8080 mode, call_addr 11'h3A5, highest_request 8'h20 -> bytes 8'hCD, then 8'hB4, then 8'h74.
REQ-047 auto_eoi 1 with rotate_aeoi set, highest_request 8'h08 -> end_interrupt 8'h08 one cycle after the final rising edge, and priority_rotate 3'd3.
REQ-048 highest_request 0 at the first pulse -> no interrupt pulse, vector level 7, no end_interrupt even with auto_eoi 1.
REQ-049 ocw2 8'hA0 with highest_level_in_service 8'h10 -> end_interrupt 8'h10 and priority_rotate 3'd4; then ocw2 8'hC1 -> priority_rotate 3'd1 and no EOI.
REQ-050 reset asserted during ACK2 -> next cycle IDLE, data_out_en 0, priority_rotate 3'b111, no end_interrupt.
